// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Holds the program counter and runs the instruction-fetch datapath that
// services the strobes from the PC control unit.
//   - Normal fetch: the byte at the current PC is read. One cycle later it is
//     captured into IR (byte_sel_i=0) or into IMM (byte_sel_i=1).
//   - Vector loads (reset/interrupt): the target PC is stored in instruction
//     memory at RESET_VEC or INTR_VEC. Loading it needs a read cycle plus a
//     V_LOAD cycle, and fetch_stall_o is high during the V_LOAD cycle.
// Ports
//   clk_i          system clock; all state changes on the rising edge
//   reset_i        synchronous active-high reset
//   pc_en_i        PC update enable
//   pc_load_i      1: load PC from pc_src_i; 0 (with pc_en_i): increment PC
//   pc_src_i       00 M[RESET_VEC], 01 M[INTR_VEC], 10 rb_data_i, 11 stack_data_i
//   byte_sel_i     fetch destination: 0 IR, 1 IMM
//   if_en_i        fetch enable: read memory at the current PC
//   rb_data_i      branch/jump/call target
//   stack_data_i   return address for RET/RTI
//   mem_addr_o     instruction-memory read address (combinational)
//   mem_rd_o       instruction-memory read strobe (combinational)
//   mem_rdata_i    read data, valid the cycle after mem_rd_o
//   pc_o           current PC (registered)
//   pc_plus1_o     pc_o + 1, wrapping; return address for CALL
//   ir_o, imm_o    instruction register / immediate byte
//   opcode_o       ir[7:4]
//   brx_o          ir[3:2]
//   fetch_stall_o  high while a vector load is completing
module pc_fetch_unit #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int RESET_VEC = 0,
    parameter int INTR_VEC  = 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          pc_en_i,
    input  logic          pc_load_i,
    input  logic [1:0]    pc_src_i,
    input  logic          byte_sel_i,
    input  logic          if_en_i,
    input  logic [AW-1:0] rb_data_i,
    input  logic [AW-1:0] stack_data_i,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_rd_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic [AW-1:0] pc_o,
    output logic [AW-1:0] pc_plus1_o,
    output logic [DW-1:0] ir_o,
    output logic [DW-1:0] imm_o,
    output logic [3:0]    opcode_o,
    output logic [1:0]    brx_o,
    output logic          fetch_stall_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        V_LOAD = 1'b1
    } state_t;

    localparam logic [AW-1:0] RESET_ADDR = AW'(RESET_VEC);
    localparam logic [AW-1:0] INTR_ADDR  = AW'(INTR_VEC);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] imm_q, imm_d;
    logic          cap_ir_q, cap_ir_d;
    logic          cap_imm_q, cap_imm_d;

    logic          vreq_s;
    logic [AW-1:0] vec_addr_s;
    logic [AW-1:0] pc_inc_s;
    logic          mem_rd_s;
    logic          stall_s;

    // A PC load from pc_src 00/01 is a vector request. It needs a memory read.
    assign vreq_s     = pc_en_i & pc_load_i & ~pc_src_i[1];
    assign vec_addr_s = pc_src_i[0] ? INTR_ADDR : RESET_ADDR;
    assign pc_inc_s   = pc_q + {{(AW-1){1'b0}}, 1'b1};

    // Next-state, PC update and memory-port control
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cap_ir_d   = 1'b0;
        cap_imm_d  = 1'b0;
        mem_addr_o = pc_q;
        mem_rd_s   = 1'b0;
        stall_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (vreq_s) begin
                    // The vector read owns the port, so if_en_i is ignored this cycle.
                    mem_addr_o = vec_addr_s;
                    mem_rd_s   = 1'b1;
                    state_d    = V_LOAD;
                end else begin
                    if (pc_en_i) begin
                        if (pc_load_i) begin
                            pc_d = pc_src_i[0] ? stack_data_i : rb_data_i;
                        end else begin
                            pc_d = pc_inc_s;
                        end
                    end else begin
                        pc_d = pc_q;
                    end
                    if (if_en_i) begin
                        // Read at the pre-increment PC: the fetched byte is the one at pc.
                        mem_rd_s  = 1'b1;
                        cap_ir_d  = ~byte_sel_i;
                        cap_imm_d = byte_sel_i;
                    end else begin
                        mem_rd_s = 1'b0;
                    end
                end
            end
            V_LOAD: begin
                // The vector target wins over any same-cycle PC request.
                stall_s = 1'b1;
                pc_d    = AW'(mem_rdata_i);
                if (vreq_s) begin
                    mem_addr_o = vec_addr_s;
                    mem_rd_s   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Load IR/IMM from the memory word selected by the previous cycle's capture flags
    always_comb begin
        ir_d  = ir_q;
        imm_d = imm_q;
        if (cap_ir_q) begin
            ir_d = mem_rdata_i;
        end else begin
            ir_d = ir_q;
        end
        if (cap_imm_q) begin
            imm_d = mem_rdata_i;
        end else begin
            imm_d = imm_q;
        end
    end

    // State registers. Reset also aborts a pending vector load, so its read data is dropped.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            imm_q     <= '0;
            cap_ir_q  <= 1'b0;
            cap_imm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            imm_q     <= imm_d;
            cap_ir_q  <= cap_ir_d;
            cap_imm_q <= cap_imm_d;
        end
    end

    // The read strobe and stall stay low while reset is asserted.
    assign mem_rd_o      = mem_rd_s & ~reset_i;
    assign fetch_stall_o = stall_s & ~reset_i;
    assign pc_o          = pc_q;
    assign pc_plus1_o    = pc_inc_s;
    assign ir_o          = ir_q;
    assign imm_o         = imm_q;
    assign opcode_o      = ir_q[7:4];
    assign brx_o         = ir_q[3:2];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit. A behavioural instruction memory with
// one cycle of read latency sits on the memory port.
module tb_pc_fetch_unit;

    logic       clk;
    logic       reset;
    logic       pc_en;
    logic       pc_load;
    logic [1:0] pc_src;
    logic       byte_sel;
    logic       if_en;
    logic [7:0] rb_data;
    logic [7:0] stack_data;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata;
    logic [7:0] pc;
    logic [7:0] pc_plus1;
    logic [7:0] ir;
    logic [7:0] imm;
    logic [3:0] opcode;
    logic [1:0] brx;
    logic       fetch_stall;

    logic [7:0] mem [256];

    int vectors;
    int miscompares;

    pc_fetch_unit dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .pc_en_i       (pc_en),
        .pc_load_i     (pc_load),
        .pc_src_i      (pc_src),
        .byte_sel_i    (byte_sel),
        .if_en_i       (if_en),
        .rb_data_i     (rb_data),
        .stack_data_i  (stack_data),
        .mem_addr_o    (mem_addr),
        .mem_rd_o      (mem_rd),
        .mem_rdata_i   (mem_rdata),
        .pc_o          (pc),
        .pc_plus1_o    (pc_plus1),
        .ir_o          (ir),
        .imm_o         (imm),
        .opcode_o      (opcode),
        .brx_o         (brx),
        .fetch_stall_o (fetch_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory with one cycle of read latency
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic idle_inputs();
        pc_en    = 1'b0;
        pc_load  = 1'b0;
        pc_src   = 2'b00;
        byte_sel = 1'b0;
        if_en    = 1'b0;
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        if_en = 1'b1;
        reset = 1'b1;
        step();
        #1;
        vectors++;
        if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL t1_rd_in_reset got %b expected 0", mem_rd); end
        step();
        step();
        if_en = 1'b0;
        reset = 1'b0;
        #1;
        vectors++;
        if (pc !== 8'h00) begin miscompares++; $display("FAIL t1_pc got %h expected 00", pc); end
        vectors++;
        if (ir !== 8'h00) begin miscompares++; $display("FAIL t1_ir got %h expected 00", ir); end
        vectors++;
        if (imm !== 8'h00) begin miscompares++; $display("FAIL t1_imm got %h expected 00", imm); end
        vectors++;
        if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL t1_rd got %b expected 0", mem_rd); end
        vectors++;
        if (fetch_stall !== 1'b0) begin miscompares++; $display("FAIL t1_stall got %b expected 0", fetch_stall); end
    endtask

    task automatic test_reset_vector();
        pc_en = 1'b1; pc_load = 1'b1; pc_src = 2'b00;
        #1;
        vectors++;
        if (mem_addr !== 8'h00) begin miscompares++; $display("FAIL t2_addr got %h expected 00", mem_addr); end
        vectors++;
        if (mem_rd !== 1'b1) begin miscompares++; $display("FAIL t2_rd got %b expected 1", mem_rd); end
        step();
        idle_inputs();
        #1;
        vectors++;
        if (fetch_stall !== 1'b1) begin miscompares++; $display("FAIL t2_stall got %b expected 1", fetch_stall); end
        vectors++;
        if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL t2_rd_vload got %b expected 0", mem_rd); end
        step();
        vectors++;
        if (pc !== 8'h20) begin miscompares++; $display("FAIL t2_pc got %h expected 20", pc); end
        vectors++;
        if (fetch_stall !== 1'b0) begin miscompares++; $display("FAIL t2_stall_after got %b expected 0", fetch_stall); end
    endtask

    task automatic test_fetch();
        if_en = 1'b1; pc_en = 1'b1; byte_sel = 1'b0;
        #1;
        chk8("t3_addr0", mem_addr, 8'h20);
        vectors++;
        if (mem_rd !== 1'b1) begin miscompares++; $display("FAIL t3_rd got %b expected 1", mem_rd); end
        step();
        byte_sel = 1'b1;
        #1;
        chk8("t3_addr1", mem_addr, 8'h21);
        step();
        idle_inputs();
        #1;
        chk8("t3_ir", ir, 8'hC4);
        vectors++;
        if (opcode !== 4'hC) begin miscompares++; $display("FAIL t3_opcode got %h expected c", opcode); end
        vectors++;
        if (brx !== 2'd1) begin miscompares++; $display("FAIL t3_brx got %0d expected 1", brx); end
        step();
        chk8("t3_imm", imm, 8'h3A);
        chk8("t3_pc", pc, 8'h22);
        chk8("t3_ir_hold", ir, 8'hC4);
    endtask

    task automatic test_jump_ret();
        pc_en = 1'b1; pc_load = 1'b1; pc_src = 2'b10; rb_data = 8'h47; stack_data = 8'h90;
        step();
        chk8("t4_pc_rb", pc, 8'h47);
        chk8("t4_pc_plus1", pc_plus1, 8'h48);
        pc_src = 2'b11;
        step();
        chk8("t4_pc_stack", pc, 8'h90);
        // pc_load without pc_en must leave pc alone
        pc_en = 1'b0; pc_src = 2'b10;
        step();
        chk8("t4_load_no_en", pc, 8'h90);
        idle_inputs();
    endtask

    task automatic test_wrap();
        pc_en = 1'b1; pc_load = 1'b1; pc_src = 2'b10; rb_data = 8'hFF;
        step();
        idle_inputs();
        if_en = 1'b1; pc_en = 1'b1;
        #1;
        chk8("t5_addr", mem_addr, 8'hFF);
        step();
        idle_inputs();
        #1;
        chk8("t5_pc", pc, 8'h00);
        chk8("t5_pc_plus1", pc_plus1, 8'h01);
        step();
        chk8("t5_ir", ir, 8'h5B);
    endtask

    task automatic test_back_to_back();
        // Hold an interrupt vector request for three cycles with if_en also high.
        pc_en = 1'b1; pc_load = 1'b1; pc_src = 2'b01; if_en = 1'b1;
        #1;
        chk8("t6_addr", mem_addr, 8'h01);
        step();
        #1;
        vectors++;
        if (fetch_stall !== 1'b1) begin miscompares++; $display("FAIL t6_stall1 got %b expected 1", fetch_stall); end
        vectors++;
        if (mem_rd !== 1'b1) begin miscompares++; $display("FAIL t6_reissue got %b expected 1", mem_rd); end
        step();
        chk8("t6_pc1", pc, 8'h80);
        step();
        chk8("t6_pc2", pc, 8'h80);
        vectors++;
        if (fetch_stall !== 1'b1) begin miscompares++; $display("FAIL t6_stall3 got %b expected 1", fetch_stall); end
        chk8("t6_ir_unchanged", ir, 8'h5B);
        idle_inputs();
        reset = 1'b1;
        #1;
        vectors++;
        if (fetch_stall !== 1'b0) begin miscompares++; $display("FAIL t6_stall_in_reset got %b expected 0", fetch_stall); end
        step();
        reset = 1'b0;
        #1;
        chk8("t6_pc_reset", pc, 8'h00);
        chk8("t6_ir_reset", ir, 8'h00);
        vectors++;
        if (fetch_stall !== 1'b0) begin miscompares++; $display("FAIL t6_stall_idle got %b expected 0", fetch_stall); end
        vectors++;
        if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL t6_rd_idle got %b expected 0", mem_rd); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h20;
        mem[8'h01] = 8'h80;
        mem[8'h20] = 8'hC4;
        mem[8'h21] = 8'h3A;
        mem[8'hFF] = 8'h5B;
        mem_rdata  = 8'h00;
        rb_data    = 8'h00;
        stack_data = 8'h00;
        idle_inputs();
        reset = 1'b1;
        #2;
        test_reset();
        test_reset_vector();
        test_fetch();
        test_jump_ret();
        test_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
